// File: rtl/glip_uart_transceiver.sv
// glip_uart_transceiver: parametrised UART (width, parity, stop bits) with on-chip RX/TX FIFOs,
// RTS driven from RX FIFO fill, CTS-gated transmit and sticky frame/parity/overrun flags.
// Optional feature macro: GLIP_UART_LOOPBACK_EN adds a 'loopback' input that routes the internal
// TX stream into the RX synchroniser, holds uart_tx high and treats CTS as asserted.
module glip_uart_transceiver #(
  parameter int unsigned DIVISOR       = 868,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 16,
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned RTS_THRESHOLD = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic [DATA_WIDTH-1:0]            rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_fill,
  input  logic                             uart_rx,
  output logic                             uart_tx,
  input  logic                             uart_cts,
  output logic                             uart_rts,
  output logic                             error_frame,
  output logic                             error_parity,
  output logic                             error_overrun,
  input  logic                             error_clear
`ifdef GLIP_UART_LOOPBACK_EN
  ,
  input  logic                             loopback
`endif
);

  localparam int unsigned CW  = $clog2(DIVISOR);
  localparam int unsigned BW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned RAW = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned TAW = $clog2(TX_FIFO_DEPTH);

  localparam logic [CW-1:0]  CntMax       = CW'(DIVISOR - 1);
  localparam logic [CW-1:0]  CntHalf      = CW'(DIVISOR / 2);
  localparam logic [BW-1:0]  LastData     = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]  LastStop     = BW'(STOP_BITS - 1);
  localparam logic           OddParity    = (PARITY == 2);
  localparam logic [RAW:0]   RxDepth      = (RAW + 1)'(RX_FIFO_DEPTH);
  localparam logic [RAW:0]   RtsThreshold = (RAW + 1)'(RTS_THRESHOLD);
  localparam logic [TAW:0]   TxDepth      = (TAW + 1)'(TX_FIFO_DEPTH);

  localparam logic [2:0] TxIdle = 3'd0, TxStart = 3'd1, TxData = 3'd2, TxParity = 3'd3,
                         TxStop = 3'd4;
  localparam logic [2:0] RxIdle = 3'd0, RxStart = 3'd1, RxData = 3'd2, RxParity = 3'd3,
                         RxStop = 3'd4, RxWaitHigh = 3'd5;

  logic       tx_line, rx_in, cts_eff;
  logic [1:0] rx_sync, cts_sync;
  logic       rx_s, rx_prev;

`ifdef GLIP_UART_LOOPBACK_EN
  assign rx_in   = loopback ? tx_line : uart_rx;
  assign uart_tx = loopback ? 1'b1 : tx_line;
  assign cts_eff = loopback ? 1'b0 : cts_sync[1];
`else
  assign rx_in   = uart_rx;
  assign uart_tx = tx_line;
  assign cts_eff = cts_sync[1];
`endif

  assign rx_s = rx_sync[1];

  // Two-flop synchronisers for the asynchronous pins, idle-high; rx_prev feeds edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      cts_sync <= 2'b11;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync  <= {rx_sync[0], rx_in};
      cts_sync <= {cts_sync[0], uart_cts};
      rx_prev  <= rx_s;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [TX_FIFO_DEPTH];
  logic [TAW-1:0]        tx_wr, tx_rd;
  logic [TAW:0]          tx_count;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_full  = (tx_count == TxDepth);
  assign tx_empty = (tx_count == '0);
  assign tx_ready = ~tx_full & ~rst;
  assign tx_push  = tx_valid & ~tx_full;
  assign tx_head  = tx_mem[tx_rd];

  // TX FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]            tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [BW-1:0]         tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par, tx_start;

  // A frame starts from idle, or directly at the end of the last stop bit so there is no gap.
  assign tx_start = ~tx_empty & ~cts_eff &
                    ((tx_state == TxIdle) ||
                     (tx_state == TxStop && tx_cnt == CntMax && tx_bit == LastStop));
  assign tx_pop   = tx_start;

  // Transmit sequencer: each bit held for DIVISOR cycles on a registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TxIdle;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else if (tx_start) begin
      tx_state <= TxStart;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= tx_head;
      tx_par   <= (^tx_head) ^ OddParity;
      tx_line  <= 1'b0;
    end else if (tx_state != TxIdle) begin
      if (tx_cnt != CntMax) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          TxStart: begin
            tx_state <= TxData;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          TxData: begin
            if (tx_bit != LastData) begin
              tx_bit   <= tx_bit + 1'b1;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end else if (PARITY != 0) begin
              tx_state <= TxParity;
              tx_line  <= tx_par;
            end else begin
              tx_state <= TxStop;
              tx_bit   <= '0;
              tx_line  <= 1'b1;
            end
          end
          TxParity: begin
            tx_state <= TxStop;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
          end
          TxStop: begin
            if (tx_bit != LastStop) begin
              tx_bit <= tx_bit + 1'b1;
            end else begin
              tx_state <= TxIdle;
              tx_line  <= 1'b1;
            end
          end
          default: begin
            tx_state <= TxIdle;
            tx_line  <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------- RX FSM ----------------
  logic [2:0]            rx_state;
  logic [CW-1:0]         rx_cnt;
  logic [BW-1:0]         rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_par, rx_perr, rx_push, rx_full;
  logic                  stop_sample, stop_done, frame_set, parity_set, overrun_set;

  assign stop_sample = (rx_state == RxStop) && (rx_cnt == CntMax);
  assign frame_set   = stop_sample & ~rx_s;
  assign stop_done   = stop_sample & rx_s & (rx_bit == LastStop);
  assign parity_set  = stop_done & rx_perr;
  assign overrun_set = stop_done & ~rx_perr & rx_full;

  // Receive sequencer: mid-bit sampling, parity check, stop check; push is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RxIdle;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      rx_perr  <= 1'b0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= stop_done & ~rx_perr & ~rx_full;
      case (rx_state)
        RxIdle: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RxStart;
            rx_cnt   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt != CntHalf) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_par   <= 1'b0;
            rx_perr  <= 1'b0;
            // A line already high again at mid-start is a glitch.
            rx_state <= rx_s ? RxIdle : RxData;
          end
        end
        RxData: begin
          if (rx_cnt != CntMax) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
            rx_par   <= rx_par ^ rx_s;
            if (rx_bit != LastData) begin
              rx_bit <= rx_bit + 1'b1;
            end else begin
              rx_bit   <= '0;
              rx_state <= (PARITY != 0) ? RxParity : RxStop;
            end
          end
        end
        RxParity: begin
          if (rx_cnt != CntMax) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_perr  <= rx_s != (rx_par ^ OddParity);
            rx_state <= RxStop;
          end
        end
        RxStop: begin
          if (rx_cnt != CntMax) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            if (!rx_s)                   rx_state <= RxWaitHigh;
            else if (rx_bit != LastStop) rx_bit   <= rx_bit + 1'b1;
            else                         rx_state <= RxIdle;
          end
        end
        RxWaitHigh: begin
          if (rx_s) rx_state <= RxIdle;
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [RAW-1:0]        rx_wr, rx_rd;
  logic [RAW:0]          rx_count;
  logic                  rx_pop;

  assign rx_full  = (rx_count == RxDepth);
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_ready & rx_valid;
  assign rx_data  = rx_mem[rx_rd];
  assign rx_fill  = rx_count;

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  // RX FIFO pointers, occupancy and registered RTS from free-entry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
      uart_rts <= 1'b1;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;
      uart_rts <= (RxDepth - rx_count) <= RtsThreshold;
    end
  end

  // Sticky error flags; a set in the same cycle as error_clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_frame   <= 1'b0;
      error_parity  <= 1'b0;
      error_overrun <= 1'b0;
    end else begin
      error_frame   <= frame_set   | (error_frame   & ~error_clear);
      error_parity  <= parity_set  | (error_parity  & ~error_clear);
      error_overrun <= overrun_set | (error_overrun & ~error_clear);
    end
  end

endmodule

// File: tb/tb_glip_uart_transceiver.sv
// Directed bench for glip_uart_transceiver: DIVISOR=8, 8E1, RX depth 8 / RTS threshold 2, TX depth 4.
module tb_glip_uart_transceiver;

  localparam int Div = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [3:0] rx_fill;
  logic       uart_rx, uart_tx, uart_cts, uart_rts;
  logic       error_frame, error_parity, error_overrun, error_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glip_uart_transceiver #(
    .DIVISOR      (8),
    .DATA_WIDTH   (8),
    .PARITY       (1),
    .STOP_BITS    (1),
    .RX_FIFO_DEPTH(8),
    .TX_FIFO_DEPTH(4),
    .RTS_THRESHOLD(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_fill      (rx_fill),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .uart_cts     (uart_cts),
    .uart_rts     (uart_rts),
    .error_frame  (error_frame),
    .error_parity (error_parity),
    .error_overrun(error_overrun),
    .error_clear  (error_clear)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8E1-shaped frame on uart_rx with an explicit parity and stop value.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      uart_rx = bits[i];
      step(Div);
    end
    uart_rx = 1'b1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_errors();
    error_clear = 1'b1;
    step(1);
    error_clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    checks++; if (uart_rts !== 1'b1) begin errors++; $display("FAIL reset_uart_rts: got %b want 1", uart_rts); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_fill !== 4'd0) begin errors++; $display("FAIL reset_rx_fill: got %0d want 0", rx_fill); end
    checks++;
    if ({error_frame, error_parity, error_overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_errors: got %b want 000", {error_frame, error_parity, error_overrun});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_reset_uart_tx: got %b want 1", uart_tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tx_ready: got %b want 1", tx_ready); end
    step(2);
    @(negedge clk);
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL post_reset_rts: got %b want 0", uart_rts); end
  endtask

  // 0xA5: start, 1,0,1,0,0,1,0,1, even parity 0, stop; 88 cycles, every cycle checked.
  task automatic test_tx_frame();
    logic [10:0] bits;
    bit found;
    bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    step(1);
    push_tx(8'hA5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL tx_frame_start: got no start bit want start within 20 cycles");
    end else begin
      for (int c = 0; c < 11 * Div; c++) begin
        if (c > 0) @(negedge clk);
        checks++;
        if (uart_tx !== bits[c/Div]) begin
          errors++; $display("FAIL tx_frame_cycle%0d: got %b want %b", c, uart_tx, bits[c/Div]);
        end
      end
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_frame_idle: got %b want 1", uart_tx); end
    end
  endtask

  task automatic test_rx_parity();
    step(1);
    send_frame(8'h3C, 1'b0, 1'b1);
    step(4);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL par_ok_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL par_ok_data: got %h want 3c", rx_data); end
    checks++; if (error_parity !== 1'b0) begin errors++; $display("FAIL par_ok_flag: got %b want 0", error_parity); end
    checks++; if (error_frame !== 1'b0) begin errors++; $display("FAIL par_ok_frame: got %b want 0", error_frame); end
    step(1);
    pop_rx();
    @(negedge clk);
    checks++; if (rx_fill !== 4'd0) begin errors++; $display("FAIL par_ok_pop: got %0d want 0", rx_fill); end
    step(1);
    send_frame(8'h3C, 1'b1, 1'b1);
    step(4);
    @(negedge clk);
    checks++; if (rx_fill !== 4'd0) begin errors++; $display("FAIL par_bad_fill: got %0d want 0", rx_fill); end
    checks++; if (error_parity !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", error_parity); end
    step(20);
    @(negedge clk);
    checks++; if (error_parity !== 1'b1) begin errors++; $display("FAIL par_sticky: got %b want 1", error_parity); end
    step(1);
    clear_errors();
    @(negedge clk);
    checks++; if (error_parity !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", error_parity); end
  endtask

  task automatic test_frame_error();
    step(1);
    send_frame(8'h55, 1'b0, 1'b0);
    uart_rx = 1'b0;
    step(30);
    @(negedge clk);
    checks++; if (error_frame !== 1'b1) begin errors++; $display("FAIL frame_flag: got %b want 1", error_frame); end
    checks++; if (rx_fill !== 4'd0) begin errors++; $display("FAIL frame_fill: got %0d want 0", rx_fill); end
    step(1);
    uart_rx = 1'b1;
    step(10);
    send_frame(8'h5A, 1'b0, 1'b1);
    step(4);
    @(negedge clk);
    checks++; if (rx_fill !== 4'd1) begin errors++; $display("FAIL frame_recover_fill: got %0d want 1", rx_fill); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL frame_recover_data: got %h want 5a", rx_data); end
    step(1);
    pop_rx();
    clear_errors();
    @(negedge clk);
    checks++; if (error_frame !== 1'b0) begin errors++; $display("FAIL frame_clear: got %b want 0", error_frame); end
  endtask

  // Nine bytes into an 8-deep FIFO: RTS rises at fill 6 (2 free), 9th byte overruns.
  task automatic test_overrun_rts();
    logic [7:0] d;
    int exp_fill;
    step(1);
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, ^d, 1'b1);
      step(4);
      @(negedge clk);
      exp_fill = (i < 8) ? i : 8;
      checks++;
      if (rx_fill !== 4'(exp_fill)) begin
        errors++; $display("FAIL ovr_fill_%0d: got %0d want %0d", i, rx_fill, exp_fill);
      end
      checks++;
      if (uart_rts !== (i >= 6)) begin
        errors++; $display("FAIL ovr_rts_%0d: got %b want %b", i, uart_rts, (i >= 6));
      end
      checks++;
      if (error_overrun !== (i == 9)) begin
        errors++; $display("FAIL ovr_flag_%0d: got %b want %b", i, error_overrun, (i == 9));
      end
      step(1);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (rx_data !== 8'(i)) begin
        errors++; $display("FAIL ovr_pop_%0d: got %h want %h", i, rx_data, 8'(i));
      end
      step(1);
      pop_rx();
    end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b want 0", rx_valid); end
    step(2);
    @(negedge clk);
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL ovr_rts_release: got %b want 0", uart_rts); end
    step(1);
    clear_errors();
  endtask

  task automatic test_cts();
    logic [10:0] f1;
    logic [21:0] f23;
    bit found;
    f1  = {1'b1, ^8'h11, 8'h11, 1'b0};
    f23 = {1'b1, ^8'h33, 8'h33, 1'b0, 1'b1, ^8'h22, 8'h22, 1'b0};
    step(1);
    uart_cts = 1'b1;
    step(4);
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL cts_hold_cycle%0d: got %b want 1", c, uart_tx); end
    end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL cts_tx_ready: got %b want 1", tx_ready); end
    uart_cts = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL cts_release_start: got no start want start within 3 cycles");
      return;
    end
    // Cycle 0 of frame 1 is the current sample; CTS goes high again mid-frame.
    for (int c = 0; c < 11 * Div; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (uart_tx !== f1[c/Div]) begin
        errors++; $display("FAIL cts_frame1_cycle%0d: got %b want %b", c, uart_tx, f1[c/Div]);
      end
      if (c == 20) uart_cts = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL cts_held_cycle%0d: got %b want 1", c, uart_tx); end
    end
    uart_cts = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL cts_frame2_start: got no start want start within 5 cycles");
      return;
    end
    for (int c = 0; c < 22 * Div; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (uart_tx !== f23[c/Div]) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b want %b", c, uart_tx, f23[c/Div]);
      end
    end
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b want 1", uart_tx); end
  endtask

  task automatic test_glitch();
    step(1);
    uart_rx = 1'b0;
    step(1);
    uart_rx = 1'b1;
    step(30);
    @(negedge clk);
    checks++; if (rx_fill !== 4'd0) begin errors++; $display("FAIL glitch_fill: got %0d want 0", rx_fill); end
    checks++;
    if ({error_frame, error_parity, error_overrun} !== 3'b000) begin
      errors++; $display("FAIL glitch_errors: got %b want 000", {error_frame, error_parity, error_overrun});
    end
  endtask

  task automatic test_reset_mid_tx();
    bit found;
    step(1);
    push_tx(8'h00);
    push_tx(8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_start: got no start want start within 20 cycles");
    end
    step(20);
    @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rstmid_before: got %b want 0", uart_tx); end
    step(1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_uart_tx: got %b want 1", uart_tx); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tx_ready: got %b want 0", tx_ready); end
    step(1);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_empty_cycle%0d: got %b want 1", c, uart_tx); end
    end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", tx_ready); end
  endtask

  initial begin
    rst         = 1'b1;
    tx_data     = '0;
    tx_valid    = 1'b0;
    rx_ready    = 1'b0;
    uart_rx     = 1'b1;
    uart_cts    = 1'b0;
    error_clear = 1'b0;
    test_reset();
    test_tx_frame();
    test_rx_parity();
    test_frame_error();
    test_overrun_rts();
    test_cts();
    test_glitch();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
